// File: rtl/fft8_pkg.sv
// fft8_pkg: shared state type, bit-reverse helper, twiddle constant and the
// fixed 12-step butterfly schedule used by fft8_stream.
package fft8_pkg;

   typedef enum logic [1:0] {
      LOAD    = 2'd0,
      COMPUTE = 2'd1,
      UNLOAD  = 2'd2
   } fft8_state_e;

   typedef struct packed {
      logic [1:0] stage;
      logic [2:0] pa;
      logic [2:0] pb;
      logic [1:0] tw;
   } bfly_step_t;

   localparam int NUM_STEPS = 12;

   function automatic logic [2:0] bitrev3(input logic [2:0] k);
      return {k[0], k[1], k[2]};
   endfunction

   // round(cos(45 deg) * 2^frac_w), evaluated with integer arithmetic
   function automatic int tw45(input int frac_w);
      longint num;
      num = longint'(70710678) * (longint'(1) <<< frac_w) + longint'(50000000);
      return int'(num / longint'(100000000));
   endfunction

   // In-place DIT over a bit-reversed buffer: stage s pairs are 2^s apart,
   // twiddle index n = j * 8 / 2^(s+1) for position j within a group.
   localparam bfly_step_t SCHED [NUM_STEPS] = '{
      '{2'd0, 3'd0, 3'd1, 2'd0},
      '{2'd0, 3'd2, 3'd3, 2'd0},
      '{2'd0, 3'd4, 3'd5, 2'd0},
      '{2'd0, 3'd6, 3'd7, 2'd0},
      '{2'd1, 3'd0, 3'd2, 2'd0},
      '{2'd1, 3'd1, 3'd3, 2'd2},
      '{2'd1, 3'd4, 3'd6, 2'd0},
      '{2'd1, 3'd5, 3'd7, 2'd2},
      '{2'd2, 3'd0, 3'd4, 2'd0},
      '{2'd2, 3'd1, 3'd5, 2'd1},
      '{2'd2, 3'd2, 3'd6, 2'd2},
      '{2'd2, 3'd3, 3'd7, 2'd3}
   };

endpackage

// File: rtl/fft8_bfly.sv
// fft8_bfly: combinational radix-2 butterfly A' = A + W*B, B' = A - W*B with W = W8^tw.
// Build option: FFT8_SAT_EN saturates the sums; otherwise they wrap to DATA_W.
module fft8_bfly
   import fft8_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 8
) (
   input  logic signed [DATA_W-1:0] a_re,
   input  logic signed [DATA_W-1:0] a_im,
   input  logic signed [DATA_W-1:0] b_re,
   input  logic signed [DATA_W-1:0] b_im,
   input  logic        [1:0]        tw,
   output logic signed [DATA_W-1:0] p_re,
   output logic signed [DATA_W-1:0] p_im,
   output logic signed [DATA_W-1:0] q_re,
   output logic signed [DATA_W-1:0] q_im
);

   localparam int PW = 2*DATA_W + 4;
   localparam int XW = DATA_W + 2;
   localparam int SW = DATA_W + 3;
   localparam logic signed [PW-1:0] C45 = PW'(tw45(FRAC_W));

   logic signed [PW-1:0] br, bi, sp, sm;
   logic signed [XW-1:0] wb_re, wb_im;
   logic signed [SW-1:0] s_re, s_im, d_re, d_im;

   assign br = PW'(b_re);
   assign bi = PW'(b_im);
   // W1 = C(1 - j), W3 = -C(1 + j): both reduce to these two full-width sums
   assign sp = C45*br + C45*bi;
   assign sm = C45*bi - C45*br;

   always_comb begin
      wb_re = '0;
      wb_im = '0;
      case (tw)
         2'd0: begin
            wb_re = XW'(b_re);
            wb_im = XW'(b_im);
         end
         2'd1: begin
            wb_re = XW'(sp >>> FRAC_W);
            wb_im = XW'(sm >>> FRAC_W);
         end
         2'd2: begin
            wb_re = XW'(b_im);
            wb_im = -XW'(b_re);
         end
         default: begin
            wb_re = XW'(sm >>> FRAC_W);
            wb_im = XW'((-sp) >>> FRAC_W);
         end
      endcase
   end

   assign s_re = SW'(a_re) + SW'(wb_re);
   assign s_im = SW'(a_im) + SW'(wb_im);
   assign d_re = SW'(a_re) - SW'(wb_re);
   assign d_im = SW'(a_im) - SW'(wb_im);

`ifdef FFT8_SAT_EN
   localparam logic signed [SW-1:0] VMAX = {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [SW-1:0] VMIN = {{(SW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   function automatic logic signed [DATA_W-1:0] reduce(input logic signed [SW-1:0] v);
      if (v > VMAX) return DATA_W'(VMAX);
      if (v < VMIN) return DATA_W'(VMIN);
      return DATA_W'(v);
   endfunction
`else
   function automatic logic signed [DATA_W-1:0] reduce(input logic signed [SW-1:0] v);
      return DATA_W'(v);
   endfunction
`endif

   assign p_re = reduce(s_re);
   assign p_im = reduce(s_im);
   assign q_re = reduce(d_re);
   assign q_im = reduce(d_im);

endmodule

// File: rtl/fft8_stream.sv
// fft8_stream: 8-point streaming FFT; load 8 samples, run 12 in-place butterflies, unload bins 0..7.
// Build option: define FFT8_SAT_EN to saturate butterfly sums instead of wrapping.
module fft8_stream
   import fft8_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_re,
   input  logic signed [DATA_W-1:0] in_im,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_re,
   output logic signed [DATA_W-1:0] out_im,
   output logic        [2:0]        out_idx,
   output logic                     out_last,
   output logic                     busy
);

   fft8_state_e            state;
   logic [2:0]             smp_cnt;
   logic [2:0]             nxt_idx;
   logic [3:0]             step;
   logic [7:0][DATA_W-1:0] mem_re, mem_im;
   logic [2:0]             pa, pb;
   logic [1:0]             tw;
   logic signed [DATA_W-1:0] p_re, p_im, q_re, q_im;
   logic                   in_fire;

   assign in_ready = (state == LOAD);
   assign busy     = (state != LOAD);
   assign in_fire  = in_valid && in_ready;
   assign nxt_idx  = out_idx + 3'd1;
   assign pa       = SCHED[step].pa;
   assign pb       = SCHED[step].pb;
   assign tw       = SCHED[step].tw;

   fft8_bfly #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W)
   ) u_bfly (
      .a_re (mem_re[pa]),
      .a_im (mem_im[pa]),
      .b_re (mem_re[pb]),
      .b_im (mem_im[pb]),
      .tw   (tw),
      .p_re (p_re),
      .p_im (p_im),
      .q_re (q_re),
      .q_im (q_im)
   );

   // Buffer is deliberately not reset; every frame rewrites all 8 entries.
   always_ff @(posedge clk) begin
      if (in_fire) begin
         mem_re[bitrev3(smp_cnt)] <= in_re;
         mem_im[bitrev3(smp_cnt)] <= in_im;
      end else if (state == COMPUTE) begin
         mem_re[pa] <= p_re;
         mem_im[pa] <= p_im;
         mem_re[pb] <= q_re;
         mem_im[pb] <= q_im;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= LOAD;
         smp_cnt   <= '0;
         step      <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_re    <= '0;
         out_im    <= '0;
         out_idx   <= '0;
      end else begin
         case (state)
            LOAD: begin
               if (in_valid) begin
                  smp_cnt <= smp_cnt + 3'd1;
                  if (smp_cnt == 3'd7) begin
                     state <= COMPUTE;
                     step  <= '0;
                  end
               end
            end
            COMPUTE: begin
               step <= step + 4'd1;
               // bin 0 is final after step 8, so it can be presented as the last step retires
               if (step == 4'(NUM_STEPS-1)) begin
                  state     <= UNLOAD;
                  step      <= '0;
                  out_valid <= 1'b1;
                  out_last  <= 1'b0;
                  out_idx   <= '0;
                  out_re    <= mem_re[0];
                  out_im    <= mem_im[0];
               end
            end
            UNLOAD: begin
               if (out_ready) begin
                  if (out_idx == 3'd7) begin
                     state     <= LOAD;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                  end else begin
                     out_idx  <= nxt_idx;
                     out_re   <= mem_re[nxt_idx];
                     out_im   <= mem_im[nxt_idx];
                     out_last <= (nxt_idx == 3'd7);
                  end
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_fft8_stream.sv
// tb_fft8_stream: randomized self-checking bench for fft8_stream against a stage-loop FFT model.
module tb_fft8_stream;

   localparam int DW  = 16;
   localparam int FW  = 8;
   localparam int C45 = 181;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0;
   logic out_ready = 1'b0;
   logic signed [DW-1:0] in_re = '0, in_im = '0;
   logic in_ready, out_valid, out_last, busy;
   logic signed [DW-1:0] out_re, out_im;
   logic [2:0] out_idx;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fft8_stream #(.DATA_W(DW), .FRAC_W(FW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
      .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
      .out_idx(out_idx), .out_last(out_last), .busy(busy)
   );

   function automatic int red(input longint v);
      logic [15:0] t;
`ifdef FFT8_SAT_EN
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return int'(v);
`else
      t = v[15:0];
      return int'($signed(t));
`endif
   endfunction

   // Reference: bit-reversed load, then log2(8) stages of DIT butterflies.
   task automatic fft_model(input int xr[8], input int xi[8], output int yr[8], output int yi[8]);
      longint tr, ti, wr, wi, br, bi, ar0, ai0;
      int rk;
      for (int k = 0; k < 8; k++) begin
         rk = ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
         yr[rk] = xr[k];
         yi[rk] = xi[k];
      end
      for (int s = 0; s < 3; s++) begin
         for (int g = 0; g < 8; g += (2 << s)) begin
            for (int j = 0; j < (1 << s); j++) begin
               int a, b, n;
               a = g + j; b = a + (1 << s); n = j * (4 >> s);
               br = yr[b]; bi = yi[b]; ar0 = yr[a]; ai0 = yi[a];
               if (n == 0) begin tr = br; ti = bi; end
               else if (n == 2) begin tr = bi; ti = -br; end
               else begin
                  wr = (n == 1) ? C45 : -C45;
                  wi = -C45;
                  tr = (wr*br - wi*bi) >>> FW;
                  ti = (wr*bi + wi*br) >>> FW;
               end
               yr[a] = red(ar0 + tr); yi[a] = red(ai0 + ti);
               yr[b] = red(ar0 - tr); yi[b] = red(ai0 - ti);
            end
         end
      end
   endtask

   task automatic send_frame(input int xr[8], input int xi[8], input bit gaps, output bit tmo);
      int k = 0, guard = 0;
      tmo = 0;
      while (k < 8) begin
         @(negedge clk);
         in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         in_re = 16'(xr[k]);
         in_im = 16'(xi[k]);
         if (in_valid && in_ready) k++;
         guard++;
         if (guard > 400) begin tmo = 1; break; end
      end
      if (!tmo) @(posedge clk);
   endtask

   task automatic collect(input int stall_bin, input int stall_len, input bit rnd,
                          output int lat, output int orr[8], output int oii[8],
                          output int oidx[8], output int olast[8],
                          output int hold_bad, output bit tmo, output bit extra);
      int sc = 0, guard = 0, nx = 0;
      int s_re = 0, s_im = 0, s_idx = 0, s_last = 0;
      bit held = 0, rdy;
      lat = 0; hold_bad = 0; tmo = 0; extra = 0;
      for (int i = 0; i < 8; i++) begin orr[i] = 0; oii[i] = 0; oidx[i] = -1; olast[i] = -1; end
      @(negedge clk);
      lat = 1;
      in_valid = rnd ? 1'(($urandom_range(0, 1))) : 1'b0;
      in_re = 16'($urandom);
      out_ready = 1'b0;
      while (!out_valid && lat < 60) begin
         @(negedge clk);
         lat++;
         if (rnd) in_valid = 1'($urandom_range(0, 1));
      end
      if (!out_valid) begin tmo = 1; in_valid = 0; return; end
      while (nx < 8 && guard < 300) begin
         if (held && (int'(out_re) != s_re || int'(out_im) != s_im ||
                      int'(out_idx) != s_idx || int'(out_last) != s_last)) hold_bad++;
         if (nx == stall_bin && sc < stall_len) begin rdy = 0; sc++; end
         else if (rnd) rdy = ($urandom_range(0, 2) != 0);
         else rdy = 1;
         out_ready = rdy;
         if (rnd) in_valid = 1'($urandom_range(0, 1));
         held = out_valid && !rdy;
         s_re = out_re; s_im = out_im; s_idx = out_idx; s_last = out_last;
         if (out_valid && rdy) begin
            orr[nx] = out_re; oii[nx] = out_im; oidx[nx] = out_idx; olast[nx] = out_last;
            nx++;
         end
         guard++;
         @(negedge clk);
      end
      if (nx < 8) tmo = 1;
      out_ready = 0;
      in_valid = 0;
      extra = out_valid;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got %b want 0", out_last); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (out_re !== 16'sd0 || out_im !== 16'sd0) begin failures++; $display("FAIL reset_out_data got %0d/%0d want 0/0", out_re, out_im); end
      checks++; if (out_idx !== 3'd0) begin failures++; $display("FAIL reset_out_idx got %0d want 0", out_idx); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Runs one frame and compares every bin against the model; optional spec constants checked by callers.
   task automatic run_frame(input string nm, input int xr[8], input int xi[8], input bit gaps,
                            input int stall_bin, input int stall_len, input bit rnd,
                            output int orr[8], output int oii[8]);
      int yr[8], yi[8], oidx[8], olast[8];
      int lat, hold_bad;
      bit tmo, extra;
      fft_model(xr, xi, yr, yi);
      send_frame(xr, xi, gaps, tmo);
      checks++; if (tmo) begin failures++; $display("FAIL %s input_timeout got stuck want 8 accepts", nm); return; end
      collect(stall_bin, stall_len, rnd, lat, orr, oii, oidx, olast, hold_bad, tmo, extra);
      checks++; if (tmo) begin failures++; $display("FAIL %s output_timeout got <8 bins want 8", nm); return; end
      checks++; if (lat != 13) begin failures++; $display("FAIL %s latency got %0d want 13", nm, lat); end
      checks++; if (hold_bad != 0) begin failures++; $display("FAIL %s hold got %0d changes want 0", nm, hold_bad); end
      checks++; if (extra) begin failures++; $display("FAIL %s extra_valid got 1 want 0", nm); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL %s in_ready_after got %b want 1", nm, in_ready); end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (orr[i] != yr[i] || oii[i] != yi[i]) begin
            failures++; $display("FAIL %s bin%0d got (%0d,%0d) want (%0d,%0d)", nm, i, orr[i], oii[i], yr[i], yi[i]);
         end
         checks++;
         if (oidx[i] != i || olast[i] != (i == 7 ? 1 : 0)) begin
            failures++; $display("FAIL %s idx_last%0d got idx=%0d last=%0d want idx=%0d last=%0d", nm, i, oidx[i], olast[i], i, (i == 7));
         end
      end
   endtask

   task automatic ramp_consts(input string nm, input int orr[8], input int oii[8]);
      checks++; if (orr[0] != 9216 || oii[0] != 0) begin failures++; $display("FAIL %s X0 got (%0d,%0d) want (9216,0)", nm, orr[0], oii[0]); end
      checks++; if (orr[1] != -1024 || oii[1] < 2470 || oii[1] > 2474) begin failures++; $display("FAIL %s X1 got (%0d,%0d) want (-1024,2472+-2)", nm, orr[1], oii[1]); end
      checks++; if (orr[2] != -1024 || oii[2] != 1024) begin failures++; $display("FAIL %s X2 got (%0d,%0d) want (-1024,1024)", nm, orr[2], oii[2]); end
      checks++; if (orr[4] != -1024 || oii[4] != 0) begin failures++; $display("FAIL %s X4 got (%0d,%0d) want (-1024,0)", nm, orr[4], oii[4]); end
      checks++; if (orr[7] != -1024 || oii[7] < -2474 || oii[7] > -2470) begin failures++; $display("FAIL %s X7 got (%0d,%0d) want (-1024,-2472+-2)", nm, orr[7], oii[7]); end
   endtask

   task automatic test_ramp();
      int xr[8], xi[8], orr[8], oii[8];
      for (int k = 0; k < 8; k++) begin xr[k] = 256 * (k + 1); xi[k] = 0; end
      run_frame("ramp", xr, xi, 0, -1, 0, 0, orr, oii);
      ramp_consts("ramp", orr, oii);
   endtask

   task automatic test_impulse();
      int xr[8], xi[8], orr[8], oii[8];
      for (int k = 0; k < 8; k++) begin xr[k] = (k == 0) ? 256 : 0; xi[k] = 0; end
      run_frame("impulse", xr, xi, 0, -1, 0, 0, orr, oii);
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (orr[i] != 256 || oii[i] != 0) begin failures++; $display("FAIL impulse_const bin%0d got (%0d,%0d) want (256,0)", i, orr[i], oii[i]); end
      end
   endtask

   task automatic test_overflow();
      int xr[8], xi[8], orr[8], oii[8];
      int want0;
`ifdef FFT8_SAT_EN
      want0 = 32767;
`else
      want0 = -2048;
`endif
      for (int k = 0; k < 8; k++) begin xr[k] = 32512; xi[k] = 0; end
      run_frame("overflow", xr, xi, 0, -1, 0, 0, orr, oii);
      checks++; if (orr[0] != want0 || oii[0] != 0) begin failures++; $display("FAIL overflow_X0 got (%0d,%0d) want (%0d,0)", orr[0], oii[0], want0); end
      for (int i = 1; i < 8; i++) begin
         checks++;
         if (orr[i] != 0 || oii[i] != 0) begin failures++; $display("FAIL overflow_bin%0d got (%0d,%0d) want (0,0)", i, orr[i], oii[i]); end
      end
   endtask

   task automatic test_backpressure();
      int xr[8], xi[8], orr[8], oii[8];
      for (int k = 0; k < 8; k++) begin xr[k] = 256 * (k + 1); xi[k] = 0; end
      run_frame("backpressure", xr, xi, 1, 3, 5, 0, orr, oii);
      ramp_consts("backpressure", orr, oii);
   endtask

   task automatic test_reset_mid_compute();
      int xr[8], xi[8], orr[8], oii[8];
      bit tmo;
      for (int k = 0; k < 8; k++) begin xr[k] = 256 * (k + 1); xi[k] = 0; end
      send_frame(xr, xi, 0, tmo);
      checks++; if (tmo) begin failures++; $display("FAIL midreset input_timeout got stuck want 8 accepts"); end
      for (int c = 0; c < 6; c++) begin @(negedge clk); in_valid = 0; end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midreset_busy_before got %b want 1", busy); end
      rst_n = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midreset_in_ready got %b want 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_out_valid got %b want 0", out_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got %b want 0", busy); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin xr[k] = (k == 0) ? 256 : 0; end
      run_frame("midreset_impulse", xr, xi, 0, -1, 0, 0, orr, oii);
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (orr[i] != 256 || oii[i] != 0) begin failures++; $display("FAIL midreset_const bin%0d got (%0d,%0d) want (256,0)", i, orr[i], oii[i]); end
      end
   endtask

   task automatic test_random();
      int xr[8], xi[8], orr[8], oii[8];
      logic [15:0] u;
      for (int f = 0; f < 6; f++) begin
         for (int k = 0; k < 8; k++) begin
            u = 16'($urandom); xr[k] = (f < 3) ? int'($signed(u)) / 16 : int'($signed(u));
            u = 16'($urandom); xi[k] = (f < 3) ? int'($signed(u)) / 16 : int'($signed(u));
         end
         run_frame("random", xr, xi, 1, $urandom_range(0, 7), $urandom_range(0, 4), 1, orr, oii);
      end
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_impulse();
      test_overflow();
      test_backpressure();
      test_reset_mid_compute();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
